// File: rtl/branch_pc_unit.sv
// Next-PC stage for the single-cycle RV32I core.
// Resolves branch/jump direction and target from comparator flags and decoded
// control. Owns the architectural PC, traps misaligned control-flow targets,
// and keeps saturating taken/not-taken conditional-branch counters.
//
// Ports:
//   i_clk, i_reset        clock, synchronous active-high reset
//   i_stall               hold PC, FSM and counters this cycle
//   i_is_branch/jal/jalr  decoded instruction kind
//   i_funct3, i_imm       branch condition select, sign-extended immediate
//   i_rs1_data            JALR base register value
//   i_br_less/equal       comparator flags
//   i_trap_clr            acknowledge trap, resume at TRAP_VEC
//   o_br_un               unsigned-compare select to comparator (comb)
//   o_pc, o_pc_four       current PC (registered) and PC+4 link value
//   o_taken               control transfer taken this cycle (comb)
//   o_misalign, o_trap_pc trap pending flag and faulting PC (registered)
//   o_taken_cnt/ntaken    conditional-branch statistics counters
module branch_pc_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] TRAP_VEC = 32'h0000_0100,
    parameter int unsigned CNT_W    = 16
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_stall,
    input  logic             i_is_branch,
    input  logic             i_is_jal,
    input  logic             i_is_jalr,
    input  logic [2:0]       i_funct3,
    input  logic [31:0]      i_imm,
    input  logic [31:0]      i_rs1_data,
    input  logic             i_br_less,
    input  logic             i_br_equal,
    output logic             o_br_un,
    output logic [31:0]      o_pc,
    output logic [31:0]      o_pc_four,
    output logic             o_taken,
    output logic             o_misalign,
    output logic [31:0]      o_trap_pc,
    input  logic             i_trap_clr,
    output logic [CNT_W-1:0] o_taken_cnt,
    output logic [CNT_W-1:0] o_ntaken_cnt
);

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_TRAP = 1'b1
    } state_t;

    state_t            state_q, state_d;
    logic [31:0]       pc_d;
    logic              misalign_d;
    logic [31:0]       trap_pc_d;
    logic [CNT_W-1:0]  taken_cnt_d, ntaken_cnt_d;

    logic              sel_jalr, sel_jal, sel_branch;
    logic              cond, cond_valid;
    logic [31:0]       target, next_pc;
    logic              misalign_hit;

    // Kind priority: jalr over jal over branch.
    assign sel_jalr   = i_is_jalr;
    assign sel_jal    = i_is_jal & ~i_is_jalr;
    assign sel_branch = i_is_branch & ~i_is_jal & ~i_is_jalr;

    assign o_br_un    = i_funct3[1];
    // funct3 010/011 are not branch encodings.
    assign cond_valid = (i_funct3[2:1] != 2'b01);

    // Branch condition decode from comparator flags.
    always_comb begin
        cond = 1'b0;
        unique case (i_funct3)
            3'b000:          cond = i_br_equal;
            3'b001:          cond = ~i_br_equal;
            3'b100, 3'b110:  cond = i_br_less;
            3'b101, 3'b111:  cond = ~i_br_less;
            default:         cond = 1'b0;
        endcase
    end

    // JALR clears bit 0 of its sum; relative targets keep bit 0 (ignored).
    assign target = sel_jalr ? ((i_rs1_data + i_imm) & ~32'h1) : (o_pc + i_imm);

    assign o_taken      = (state_q == ST_RUN) & (sel_jalr | sel_jal | (sel_branch & cond));
    assign o_pc_four    = o_pc + 32'd4;
    assign next_pc      = o_taken ? target : o_pc_four;
    assign misalign_hit = o_taken & target[1];

    // Next-state and register-update decode.
    always_comb begin
        state_d      = state_q;
        pc_d         = o_pc;
        misalign_d   = o_misalign;
        trap_pc_d    = o_trap_pc;
        taken_cnt_d  = o_taken_cnt;
        ntaken_cnt_d = o_ntaken_cnt;
        unique case (state_q)
            ST_RUN: begin
                if (!i_stall) begin
                    if (misalign_hit) begin
                        state_d    = ST_TRAP;
                        trap_pc_d  = o_pc;
                        misalign_d = 1'b1;
                    end else begin
                        pc_d = next_pc;
                    end
                    // Misaligned taken branches still count as taken.
                    if (sel_branch && cond_valid) begin
                        if (cond) begin
                            if (o_taken_cnt != {CNT_W{1'b1}}) taken_cnt_d = o_taken_cnt + CNT_W'(1);
                        end else begin
                            if (o_ntaken_cnt != {CNT_W{1'b1}}) ntaken_cnt_d = o_ntaken_cnt + CNT_W'(1);
                        end
                    end
                end
            end
            ST_TRAP: begin
                if (i_trap_clr) begin
                    state_d    = ST_RUN;
                    pc_d       = TRAP_VEC;
                    misalign_d = 1'b0;
                end
            end
            default: state_d = ST_RUN;
        endcase
    end

    // State register; reset overrides stall and trap.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q      <= ST_RUN;
            o_pc         <= RESET_PC;
            o_misalign   <= 1'b0;
            o_trap_pc    <= 32'h0;
            o_taken_cnt  <= '0;
            o_ntaken_cnt <= '0;
        end else begin
            state_q      <= state_d;
            o_pc         <= pc_d;
            o_misalign   <= misalign_d;
            o_trap_pc    <= trap_pc_d;
            o_taken_cnt  <= taken_cnt_d;
            o_ntaken_cnt <= ntaken_cnt_d;
        end
    end

endmodule

// File: tb/tb_branch_pc_unit.sv
// Self-checking bench for branch_pc_unit (CNT_W=2 to reach saturation quickly).
module tb_branch_pc_unit;

    localparam int unsigned CNT_W = 2;

    logic             clk;
    logic             reset, stall, is_branch, is_jal, is_jalr, br_less, br_equal, trap_clr;
    logic [2:0]       funct3;
    logic [31:0]      imm, rs1_data;
    logic             br_un, taken, misalign;
    logic [31:0]      pc, pc_four, trap_pc;
    logic [CNT_W-1:0] taken_cnt, ntaken_cnt;

    branch_pc_unit #(
        .RESET_PC(32'h0000_0000),
        .TRAP_VEC(32'h0000_0100),
        .CNT_W(CNT_W)
    ) dut (
        .i_clk(clk), .i_reset(reset), .i_stall(stall),
        .i_is_branch(is_branch), .i_is_jal(is_jal), .i_is_jalr(is_jalr),
        .i_funct3(funct3), .i_imm(imm), .i_rs1_data(rs1_data),
        .i_br_less(br_less), .i_br_equal(br_equal),
        .o_br_un(br_un), .o_pc(pc), .o_pc_four(pc_four), .o_taken(taken),
        .o_misalign(misalign), .o_trap_pc(trap_pc), .i_trap_clr(trap_clr),
        .o_taken_cnt(taken_cnt), .o_ntaken_cnt(ntaken_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc;
        logic        mis;
        logic [31:0] tpc;
        logic [31:0] tc;
        logic [31:0] nc;
    } exp_t;

    exp_t sb[$];

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state.
    logic [31:0] m_pc, m_tpc, m_tc, m_nc;
    logic        m_trap, m_mis;
    localparam logic [31:0] CNT_MAX = 32'((1 << CNT_W) - 1);

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Drive one cycle, check combinational outputs, advance model, score registers.
    task automatic step(input logic rst, input logic stl, input logic br, input logic jl,
                        input logic jr, input logic [2:0] f3, input logic [31:0] im,
                        input logic [31:0] rs1, input logic lt, input logic eq, input logic clr);
        logic        cnd, cvalid, tk, kbr;
        logic [31:0] tgt;
        exp_t        e, got_e;
        @(negedge clk);
        reset = rst; stall = stl; is_branch = br; is_jal = jl; is_jalr = jr;
        funct3 = f3; imm = im; rs1_data = rs1; br_less = lt; br_equal = eq; trap_clr = clr;
        #1;
        case (f3)
            3'b000: cnd = eq;
            3'b001: cnd = !eq;
            3'b100, 3'b110: cnd = lt;
            3'b101, 3'b111: cnd = !lt;
            default: cnd = 1'b0;
        endcase
        cvalid = !(f3 == 3'b010 || f3 == 3'b011);
        kbr    = br && !jl && !jr;
        if (jr) tgt = (rs1 + im) & 32'hFFFF_FFFE;
        else    tgt = m_pc + im;
        tk = !m_trap && (jr || jl || (kbr && cnd));
        check("br_un", 32'(br_un), 32'(f3[1]));
        check("taken", 32'(taken), 32'(tk));
        check("pc_four", pc_four, m_pc + 32'd4);
        if (rst) begin
            m_trap = 0; m_pc = 32'h0; m_mis = 0; m_tpc = 32'h0; m_tc = 0; m_nc = 0;
        end else if (!m_trap) begin
            if (!stl) begin
                if (tk && tgt[1]) begin
                    m_trap = 1; m_mis = 1; m_tpc = m_pc;
                end else begin
                    m_pc = tk ? tgt : m_pc + 32'd4;
                end
                if (kbr && cvalid) begin
                    if (cnd) m_tc = (m_tc == CNT_MAX) ? m_tc : m_tc + 1;
                    else     m_nc = (m_nc == CNT_MAX) ? m_nc : m_nc + 1;
                end
            end
        end else if (clr) begin
            m_trap = 0; m_pc = 32'h100; m_mis = 0;
        end
        e.pc = m_pc; e.mis = m_mis; e.tpc = m_tpc; e.tc = m_tc; e.nc = m_nc;
        sb.push_back(e);
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            check("sb_empty", 32'd0, 32'd1);
        end else begin
            got_e = sb.pop_front();
            check("pc", pc, got_e.pc);
            check("misalign", 32'(misalign), 32'(got_e.mis));
            check("trap_pc", trap_pc, got_e.tpc);
            check("taken_cnt", 32'(taken_cnt), got_e.tc);
            check("ntaken_cnt", 32'(ntaken_cnt), got_e.nc);
        end
    endtask

    // Shorthands: plain sequential, branch, jal, jalr.
    task automatic seq_step(input logic stl, input logic clr);
        step(0, stl, 0, 0, 0, 3'b000, 32'h0, 32'h0, 0, 0, clr);
    endtask

    task automatic br_step(input logic stl, input logic [2:0] f3, input logic [31:0] im,
                           input logic lt, input logic eq);
        step(0, stl, 1, 0, 0, f3, im, 32'h0, lt, eq, 0);
    endtask

    initial begin
        reset = 1; stall = 0; is_branch = 0; is_jal = 0; is_jalr = 0;
        funct3 = 3'b000; imm = 32'h0; rs1_data = 32'h0; br_less = 0; br_equal = 0; trap_clr = 0;
        m_trap = 0; m_pc = 32'h0; m_mis = 0; m_tpc = 32'h0; m_tc = 0; m_nc = 0;
        @(posedge clk);
        #1;

        // Reset then sequential fetch 0x4, 0x8, 0xC, 0x10.
        step(1, 0, 0, 0, 0, 3'b000, 32'h0, 32'h0, 0, 0, 0);
        repeat (4) seq_step(0, 0);
        check("pc_at_0x10", pc, 32'h10);

        // BEQ taken then not taken.
        br_step(0, 3'b000, 32'h20, 0, 1);
        check("beq_taken_pc", pc, 32'h30);
        br_step(0, 3'b000, 32'h20, 0, 0);
        check("beq_ntaken_pc", pc, 32'h34);

        // JAL to 0x40, BLTU back 8, BGE with less=1 falls through.
        step(0, 0, 0, 1, 0, 3'b000, 32'hC, 32'h0, 0, 0, 0);
        br_step(0, 3'b110, 32'hFFFF_FFF8, 1, 0);
        check("bltu_pc", pc, 32'h38);
        br_step(0, 3'b101, 32'h40, 1, 0);
        check("bge_pc", pc, 32'h3C);

        // Trap clear in RUN is ignored; JALR clears bit 0; JALR beats JAL.
        seq_step(0, 1);
        step(0, 0, 0, 0, 1, 3'b000, 32'h4, 32'h1001, 0, 0, 0);
        check("jalr_pc", pc, 32'h1004);
        step(0, 0, 1, 1, 1, 3'b000, 32'h10, 32'h2000, 0, 1, 0);
        check("jalr_prio_pc", pc, 32'h2010);

        // Misaligned JAL at 0x50 traps; held through stall toggling.
        step(0, 0, 0, 0, 1, 3'b000, 32'h0, 32'h50, 0, 0, 0);
        step(0, 0, 0, 1, 0, 3'b000, 32'h6, 32'h0, 0, 0, 0);
        check("trap_pc_hold", pc, 32'h50);
        seq_step(1, 0);
        seq_step(0, 0);
        br_step(0, 3'b000, 32'h8, 0, 1);
        // Exit ignores stall.
        seq_step(1, 1);
        check("trap_vec_pc", pc, 32'h100);

        // Stalled taken branch changes nothing; invalid funct3 not counted.
        br_step(1, 3'b000, 32'h40, 0, 1);
        br_step(0, 3'b010, 32'h40, 1, 1);
        // Saturate taken counter (including a misaligned taken branch).
        repeat (3) br_step(0, 3'b001, 32'h10, 0, 0);
        br_step(0, 3'b000, 32'h2, 0, 1);
        check("sat_cnt", 32'(taken_cnt), 32'd3);

        // Reset while trapped.
        step(1, 1, 0, 0, 0, 3'b000, 32'h0, 32'h0, 0, 0, 0);
        check("reset_mid_trap_pc", pc, 32'h0);

        // Random phase.
        for (int i = 0; i < 300; i++) begin
            logic [31:0] rimm;
            rimm = {$urandom_range(0, 255), 2'b00};
            if ($urandom_range(0, 7) == 0) rimm[1] = 1'b1;
            step(($urandom_range(0, 40) == 0), ($urandom_range(0, 4) == 0),
                 1'($urandom), ($urandom_range(0, 5) == 0), ($urandom_range(0, 7) == 0),
                 3'($urandom), ($urandom_range(0, 1) == 0) ? rimm : -rimm,
                 $urandom, 1'($urandom), 1'($urandom), ($urandom_range(0, 2) == 0));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/branch_pc_unit.md
Name: branch_pc_unit

Overview:
Next-PC stage directly downstream of the branch comparator in the single-cycle RV32I core. Consumes the comparator's less/equal flags plus decoded control, resolves branch/jump direction and target, and owns the architectural PC register. Also supplies the unsigned-compare select back to the comparator, traps misaligned control-flow targets, and keeps saturating taken/not-taken branch counters.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset
TRAP_VEC, 32'h0000_0100, PC loaded when a trap is cleared
CNT_W, 16, width of each branch statistics counter

Ports:
i_clk  input  1  clock, all state updates on rising edge
i_reset  input  1  synchronous reset, active-high
i_stall  input  1  hold PC, FSM and counters this cycle
i_is_branch  input  1  current instruction is a conditional branch
i_is_jal  input  1  current instruction is JAL
i_is_jalr  input  1  current instruction is JALR
i_funct3  input  3  instruction funct3
i_imm  input  32  sign-extended immediate
i_rs1_data  input  32  rs1 value (JALR base)
i_br_less  input  1  comparator less flag
i_br_equal  input  1  comparator equal flag
o_br_un  output  1  unsigned compare select to comparator
o_pc  output  32  current PC (registered)
o_pc_four  output  32  o_pc + 4 (link value)
o_taken  output  1  control transfer taken this cycle
o_misalign  output  1  trap pending (registered)
o_trap_pc  output  32  PC of faulting instruction (registered)
i_trap_clr  input  1  acknowledge trap, resume at TRAP_VEC
o_taken_cnt  output  CNT_W  count of taken conditional branches
o_ntaken_cnt  output  CNT_W  count of not-taken conditional branches

Behaviour:
- Reset (synchronous, i_reset=1 at edge): FSM=RUN, o_pc=RESET_PC, o_misalign=0, o_trap_pc=0, both counters 0. Reset wins over every other input, including mid-trap and during stall.
- o_br_un = i_funct3[1] (combinational, always driven).
- Condition (combinational): 000 equal; 001 !equal; 100/110 less; 101/111 !less; 010/011 never taken.
- Kind priority when several asserted: jalr > jal > branch. None asserted: sequential.
- Target: jal/branch = o_pc + i_imm; jalr = (i_rs1_data + i_imm) & ~32'h1. All adds mod 2^32, wrap silently.
- o_taken = FSM==RUN and (jal or jalr or (branch and condition)); 0 in TRAP.
- next_pc = target if o_taken else o_pc + 4.
- Misalign: o_taken and target[1]==1 (no C extension). Bit 0 of a branch/jal target ignored.
- FSM RUN: if i_stall, hold all state. Else if misalign: go TRAP, o_pc unchanged, o_trap_pc<=o_pc, o_misalign<=1. Else o_pc<=next_pc.
- FSM TRAP: o_pc held, i_stall ignored for exit. i_trap_clr=1 -> RUN, o_pc<=TRAP_VEC, o_misalign<=0, o_trap_pc retained. i_trap_clr in RUN has no effect.
- Counters update only in RUN, not stalled, selected kind is branch, funct3 valid (not 010/011). Taken -> o_taken_cnt+1, else o_ntaken_cnt+1. Misaligned taken branch still counts as taken. Each counter saturates at all-ones.
- Latency: next PC visible on o_pc one cycle after the edge; o_taken/o_br_un are same-cycle combinational.

Test Plan:
- Reset: i_reset=1 one edge -> o_pc=0x0, o_misalign=0, counters 0; release, no control -> o_pc 0x4, 0x8, 0xC on successive edges.
- BEQ: o_pc=0x10, funct3=000, equal=1, imm=0x20 -> o_taken=1, o_pc=0x30, o_taken_cnt=1; equal=0 -> o_pc=0x34, o_ntaken_cnt=1.
- BLTU/BGE: funct3=110 -> o_br_un=1; less=1, imm=-8 at pc 0x40 -> 0x38. funct3=101, less=1 -> not taken, o_pc+4, o_br_un=0.
- JALR: rs1=0x1001, imm=0x4 -> o_pc=0x1004 (bit0 cleared); jal+jalr both set -> jalr target used.
- Misalign trap: o_pc=0x50, jal imm=0x6 -> next o_pc=0x50, o_misalign=1, o_trap_pc=0x50; stays held with stall toggling; i_trap_clr=1 -> o_pc=0x100, o_misalign=0.
- Stall/saturation/reset mid-trap: i_stall=1 with taken branch -> o_pc and counters unchanged; CNT_W=2, 4 taken branches -> o_taken_cnt=3; reset while in TRAP -> o_pc=RESET_PC, o_misalign=0.
